// File: rtl/weight_pkg.sv
// Shared constants for the weight loader: FSM state encoding, default geometry
// and a helper for sizing row/column index registers.
package weight_pkg;

    localparam int unsigned DEF_ROWS      = 4;
    localparam int unsigned DEF_COLS      = 4;
    localparam int unsigned DEF_WORD_SIZE = 16;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t LOAD = 2'd1;
    localparam state_t DONE = 2'd2;

    // Index registers need at least one bit even for a single row or column.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rc_counter.sv
// Row-major row/column position counter with synchronous clear, wrap to (0,0)
// after the final element, and a combinational flag marking that final element.
module rc_counter
    import weight_pkg::*;
#(
    parameter int unsigned ROWS = DEF_ROWS,
    parameter int unsigned COLS = DEF_COLS,
    localparam int unsigned RW  = idx_width(ROWS),
    localparam int unsigned CW  = idx_width(COLS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);

    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic          row_end;
    logic          col_end;

    assign row_end = (row_q == RW'(ROWS - 1));
    assign col_end = (col_q == CW'(COLS - 1));
    assign last    = row_end && col_end;
    assign row     = row_q;
    assign col     = col_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else if (clr) begin
            row_q <= '0;
            col_q <= '0;
        end else if (inc) begin
            if (col_end) begin
                col_q <= '0;
                row_q <= row_end ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/weight_loader.sv
// Streams ROWS*COLS weights into a PE weight buffer in row-major order, one write per handshake.
// Define WEIGHT_LOADER_CHECKSUM_EN to add a per-frame modulo-2^WORD_SIZE checksum output.
module weight_loader
    import weight_pkg::*;
#(
    parameter int unsigned ROWS      = DEF_ROWS,
    parameter int unsigned COLS      = DEF_COLS,
    parameter int unsigned WORD_SIZE = DEF_WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WORD_SIZE-1:0] s_weight,
    output logic                 we,
    output logic [ROWS-1:0]      wr_row,
    output logic [COLS-1:0]      wr_col,
    output logic [WORD_SIZE-1:0] wr_weight,
    output logic                 busy,
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    output logic [WORD_SIZE-1:0] checksum,
`endif
    output logic                 done
);

    localparam int unsigned RW = idx_width(ROWS);
    localparam int unsigned CW = idx_width(COLS);

    state_t                state_q;
    state_t                state_d;
    logic                  hs;
    logic                  cnt_clr;
    logic                  last;
    logic [RW-1:0]         row;
    logic [CW-1:0]         col;
    logic                  we_q;
    logic [ROWS-1:0]       wr_row_q;
    logic [COLS-1:0]       wr_col_q;
    logic [WORD_SIZE-1:0]  wr_weight_q;

    assign s_ready = (state_q == LOAD);
    assign busy    = (state_q == LOAD);
    // DONE is entered on the final handshake, so it lines up with the last write.
    assign done    = (state_q == DONE);
    assign hs      = s_valid && s_ready && !abort;

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_clr = 1'b1;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                end else if (hs && last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    rc_counter #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_rc_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (hs),
        .row   (row),
        .col   (col),
        .last  (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q        <= 1'b0;
            wr_row_q    <= '0;
            wr_col_q    <= '0;
            wr_weight_q <= '0;
        end else begin
            we_q <= hs;
            if (hs) begin
                wr_row_q    <= ROWS'(row);
                wr_col_q    <= COLS'(col);
                wr_weight_q <= s_weight;
            end
        end
    end

    assign we        = we_q;
    assign wr_row    = wr_row_q;
    assign wr_col    = wr_col_q;
    assign wr_weight = wr_weight_q;

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [WORD_SIZE-1:0] checksum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else if (state_q == IDLE && start) begin
            checksum_q <= '0;
        end else if (hs) begin
            checksum_q <= checksum_q + s_weight;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: a frame-level model checked every cycle,
// plus hand-computed expectations on write order, done timing, abort and reset.
module tb_weight_loader;

    localparam int R = 4;
    localparam int C = 4;
    localparam int W = 16;
    localparam int N = R * C;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [W-1:0] s_weight = '0;
    logic         we;
    logic [R-1:0] wr_row;
    logic [C-1:0] wr_col;
    logic [W-1:0] wr_weight;
    logic         busy;
    logic         done;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [W-1:0] checksum;
`endif

    weight_loader #(
        .ROWS      (R),
        .COLS      (C),
        .WORD_SIZE (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_weight  (s_weight),
        .we        (we),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_weight (wr_weight),
        .busy      (busy),
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        .checksum  (checksum),
`endif
        .done      (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Frame-level model: mode 0 idle, 1 loading, 2 completion cycle.
    int           m_mode = 0;
    int           m_idx  = 0;
    logic         e_we   = 1'b0;
    int           e_row  = 0;
    int           e_col  = 0;
    logic [W-1:0] e_w    = '0;
    logic [W-1:0] e_sum  = '0;

    // Log of observed writes and done pulses for the hand-computed checks.
    int cyc = 0;
    int log_row[$];
    int log_col[$];
    int log_w[$];
    int log_cyc[$];
    int done_cnt = 0;
    int done_cyc = -1;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_mode = 0;
            m_idx  = 0;
            e_we   = 1'b0;
            e_row  = 0;
            e_col  = 0;
            e_w    = '0;
            e_sum  = '0;
        end
        chk("m_ready", 32'(s_ready), 32'(m_mode == 1));
        chk("m_busy", 32'(busy), 32'(m_mode == 1));
        chk("m_done", 32'(done), 32'(m_mode == 2));
        chk("m_we", 32'(we), 32'(e_we));
        chk("m_row", 32'(wr_row), 32'(e_row));
        chk("m_col", 32'(wr_col), 32'(e_col));
        chk("m_weight", 32'(wr_weight), 32'(e_w));
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        chk("m_checksum", 32'(checksum), 32'(e_sum));
`endif
        if (we === 1'b1) begin
            log_row.push_back(int'(wr_row));
            log_col.push_back(int'(wr_col));
            log_w.push_back(int'(wr_weight));
            log_cyc.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (rst_n) begin
            logic hs;
            hs   = (m_mode == 1) && s_valid && !abort;
            e_we = hs;
            if (hs) begin
                e_row = m_idx / C;
                e_col = m_idx % C;
                e_w   = s_weight;
                e_sum = e_sum + s_weight;
            end
            case (m_mode)
                0: if (start) begin
                    m_mode = 1;
                    m_idx  = 0;
                    e_sum  = '0;
                end
                1: if (abort) begin
                    m_mode = 0;
                    m_idx  = 0;
                end else if (hs) begin
                    m_idx++;
                    if (m_idx == N) begin
                        m_idx  = 0;
                        m_mode = 2;
                    end
                end
                default: m_mode = 0;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic feed(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            s_valid  = 1'b1;
            s_weight = W'(base + i);
            step();
        end
        s_valid = 1'b0;
    endtask

    int lb;
    int db;

    initial begin
        // Reset values, held across edges
        step();
        step();
        chk("rst_ready", 32'(s_ready), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        step();

        // Back-to-back frame 1..16; abort during the completion cycle is ignored
        lb = log_w.size();
        db = done_cnt;
        pulse_start();
        chk("t1_busy", 32'(busy), 32'd1);
        feed(N, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        step();
        chk("t1_writes", 32'(log_w.size() - lb), 32'd16);
        chk("t1_first_row", 32'(log_row[lb]), 32'd0);
        chk("t1_first_col", 32'(log_col[lb]), 32'd0);
        chk("t1_first_w", 32'(log_w[lb]), 32'h0001);
        chk("t1_fifth_row", 32'(log_row[lb + 4]), 32'd1);
        chk("t1_fifth_col", 32'(log_col[lb + 4]), 32'd0);
        chk("t1_last_row", 32'(log_row[lb + 15]), 32'd3);
        chk("t1_last_col", 32'(log_col[lb + 15]), 32'd3);
        chk("t1_last_w", 32'(log_w[lb + 15]), 32'h0010);
        chk("t1_dones", 32'(done_cnt - db), 32'd1);
        chk("t1_done_cyc", 32'(done_cyc), 32'(log_cyc[lb + 15]));
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        chk("t1_checksum", 32'(checksum), 32'h0088);
`endif

        // s_valid toggling, with a stray start mid-load
        lb = log_w.size();
        db = done_cnt;
        pulse_start();
        for (int i = 0; i < 31; i++) begin
            s_valid  = (i % 2 == 0);
            s_weight = W'(i / 2 + 1);
            start    = (i == 10);
            step();
        end
        s_valid = 1'b0;
        start   = 1'b0;
        step();
        step();
        chk("t2_writes", 32'(log_w.size() - lb), 32'd16);
        chk("t2_span", 32'(log_cyc[lb + 15] - log_cyc[lb]), 32'd30);
        chk("t2_last_row", 32'(log_row[lb + 15]), 32'd3);
        chk("t2_last_col", 32'(log_col[lb + 15]), 32'd3);
        chk("t2_dones", 32'(done_cnt - db), 32'd1);

        // Abort after 5 handshakes, then a full frame
        lb = log_w.size();
        db = done_cnt;
        pulse_start();
        feed(5, 100);
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_writes", 32'(log_w.size() - lb), 32'd5);
        chk("t3_dones", 32'(done_cnt - db), 32'd0);
        lb = log_w.size();
        pulse_start();
        feed(N, 1);
        step();
        step();
        chk("t3_first_row", 32'(log_row[lb]), 32'd0);
        chk("t3_first_col", 32'(log_col[lb]), 32'd0);
        chk("t3_first_w", 32'(log_w[lb]), 32'h0001);
        chk("t3_dones2", 32'(done_cnt - db), 32'd1);

        // Abort together with a valid weight: no write follows
        lb = log_w.size();
        pulse_start();
        feed(3, 200);
        abort    = 1'b1;
        s_valid  = 1'b1;
        s_weight = 16'hBEEF;
        step();
        abort   = 1'b0;
        s_valid = 1'b0;
        chk("t4_we", 32'(we), 32'd0);
        chk("t4_weight", 32'(wr_weight), 32'(202));
        chk("t4_busy", 32'(busy), 32'd0);
        step();
        chk("t4_writes", 32'(log_w.size() - lb), 32'd3);
        lb = log_w.size();
        pulse_start();
        feed(N, 32'h20);
        step();
        chk("t4_first_row", 32'(log_row[lb]), 32'd0);
        chk("t4_first_col", 32'(log_col[lb]), 32'd0);
        chk("t4_first_w", 32'(log_w[lb]), 32'h0020);

        // Reset mid-load after 8 handshakes
        db = done_cnt;
        pulse_start();
        feed(8, 300);
        chk("t5_we_before", 32'(we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_we", 32'(we), 32'd0);
        chk("t5_row", 32'(wr_row), 32'd0);
        chk("t5_col", 32'(wr_col), 32'd0);
        chk("t5_weight", 32'(wr_weight), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_ready", 32'(s_ready), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("t5_dones", 32'(done_cnt - db), 32'd0);
        lb = log_w.size();
        pulse_start();
        feed(N, 1);
        step();
        chk("t5_first_row", 32'(log_row[lb]), 32'd0);
        chk("t5_first_col", 32'(log_col[lb]), 32'd0);
        chk("t5_writes", 32'(log_w.size() - lb), 32'd16);
        chk("t5_dones2", 32'(done_cnt - db), 32'd1);

`ifdef WEIGHT_LOADER_CHECKSUM_EN
        // Sixteen 0x1000 weights wrap the checksum to zero
        pulse_start();
        for (int i = 0; i < N; i++) begin
            s_valid  = 1'b1;
            s_weight = 16'h1000;
            step();
        end
        s_valid = 1'b0;
        step();
        step();
        chk("t6_checksum", 32'(checksum), 32'h0000);
`endif

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
